// File: rtl/pid_loop_scheduler_if.sv
// PID compute-unit bus for the FOC cascade sequencer.
// One start/operand/result/done group per PID unit (speed, id, iq).
//   master : the sequencer -- drives enables and operands, receives results and dones
//   slave  : the PID units -- receive enables and operands, return results and dones
interface pid_loop_scheduler_if #(
  parameter int DATA_WIDTH = 16
);
  logic                          speed_pid_enable_out;
  logic                          id_pid_enable_out;
  logic                          iq_pid_enable_out;
  logic signed [DATA_WIDTH-1:0]  speed_pid_set_out;
  logic signed [DATA_WIDTH-1:0]  speed_pid_detect_out;
  logic signed [DATA_WIDTH-1:0]  id_pid_set_out;
  logic signed [DATA_WIDTH-1:0]  id_pid_detect_out;
  logic signed [DATA_WIDTH-1:0]  iq_pid_set_out;
  logic signed [DATA_WIDTH-1:0]  iq_pid_detect_out;
  logic signed [DATA_WIDTH-1:0]  speed_pid_value_in;
  logic signed [DATA_WIDTH-1:0]  id_pid_value_in;
  logic signed [DATA_WIDTH-1:0]  iq_pid_value_in;
  logic                          speed_pid_done_in;
  logic                          id_pid_done_in;
  logic                          iq_pid_done_in;

  modport master (
    output speed_pid_enable_out, id_pid_enable_out, iq_pid_enable_out,
    output speed_pid_set_out, speed_pid_detect_out,
    output id_pid_set_out, id_pid_detect_out,
    output iq_pid_set_out, iq_pid_detect_out,
    input  speed_pid_value_in, id_pid_value_in, iq_pid_value_in,
    input  speed_pid_done_in, id_pid_done_in, iq_pid_done_in
  );

  modport slave (
    input  speed_pid_enable_out, id_pid_enable_out, iq_pid_enable_out,
    input  speed_pid_set_out, speed_pid_detect_out,
    input  id_pid_set_out, id_pid_detect_out,
    input  iq_pid_set_out, iq_pid_detect_out,
    output speed_pid_value_in, id_pid_value_in, iq_pid_value_in,
    output speed_pid_done_in, id_pid_done_in, iq_pid_done_in
  );
endinterface

// File: rtl/pid_loop_scheduler.sv
// Cascade sequencer for the FOC control loops.
// Each accepted current-loop tick snapshots the loop inputs; every SPEED_DIV-th
// tick first runs the speed PID and clamps its result into the iq reference,
// then the id and iq current PIDs run in parallel and their results are
// published as vd/vq.
// Ports:
//   sys_clk, reset_n         clock, asynchronous active-low reset
//   loop_enable_in           level enable; low aborts to IDLE and clears fault
//   current_tick_in          one-cycle tick per current-loop period
//   speed/id/iq set/detect   signed loop inputs, iq_limit_in unsigned magnitude
//   pid                      PID unit bus (master side)
//   iq_ref_out, vd_out, vq_out  signed references
//   loop_done_out            one-cycle pulse, new vd/vq valid
//   tick_overrun_out         one-cycle pulse, tick arrived while busy
//   fault_out                sticky wait-state timeout flag
module pid_loop_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int SPEED_DIV  = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         loop_enable_in,
  input  logic                         current_tick_in,
  input  logic signed [DATA_WIDTH-1:0] speed_set_in,
  input  logic signed [DATA_WIDTH-1:0] speed_detect_in,
  input  logic signed [DATA_WIDTH-1:0] id_set_in,
  input  logic signed [DATA_WIDTH-1:0] id_detect_in,
  input  logic signed [DATA_WIDTH-1:0] iq_detect_in,
  input  logic        [DATA_WIDTH-1:0] iq_limit_in,
  pid_loop_scheduler_if.master         pid,
  output logic signed [DATA_WIDTH-1:0] iq_ref_out,
  output logic signed [DATA_WIDTH-1:0] vd_out,
  output logic signed [DATA_WIDTH-1:0] vq_out,
  output logic                         loop_done_out,
  output logic                         tick_overrun_out,
  output logic                         fault_out
);

  localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic signed [DATA_WIDTH-1:0] LIM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [3:0] {
    IDLE       = 4'b0001,
    SPEED_WAIT = 4'b0010,
    CUR_WAIT   = 4'b0100,
    DONE       = 4'b1000
  } state_t;

  // Limit input is a magnitude; anything with the MSB set saturates to full scale.
  function automatic logic signed [DATA_WIDTH-1:0] sat_limit(input logic [DATA_WIDTH-1:0] lim);
    return lim[DATA_WIDTH-1] ? LIM_MAX : $signed(lim);
  endfunction

  // Symmetric clamp; lim is never negative so -lim cannot overflow.
  function automatic logic signed [DATA_WIDTH-1:0] clamp_sym(
    input logic signed [DATA_WIDTH-1:0] v,
    input logic signed [DATA_WIDTH-1:0] lim
  );
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  state_t state, state_nxt;
  logic             accept, timed_out, id_hit, iq_hit;
  logic             enter_speed, enter_cur, enter_done;
  logic [DIV_W-1:0] div_cnt;
  logic [TMR_W-1:0] tmr;
  logic             id_seen, iq_seen;

  logic signed [DATA_WIDTH-1:0] speed_set_p0, speed_detect_p0;
  logic signed [DATA_WIDTH-1:0] id_set_p0, id_detect_p0, iq_detect_p0, lim_p0;
  logic signed [DATA_WIDTH-1:0] id_res_p1, iq_res_p1;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    timed_out = 1'b0;
    id_hit    = id_seen | pid.id_pid_done_in;
    iq_hit    = iq_seen | pid.iq_pid_done_in;
    if (!loop_enable_in) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (current_tick_in && !fault_out) begin
            accept    = 1'b1;
            state_nxt = (div_cnt == '0) ? SPEED_WAIT : CUR_WAIT;
          end
        end
        SPEED_WAIT: begin
          if (pid.speed_pid_done_in) begin
            state_nxt = CUR_WAIT;
          end else if (tmr == TMR_LAST) begin
            timed_out = 1'b1;
            state_nxt = IDLE;
          end
        end
        CUR_WAIT: begin
          if (id_hit && iq_hit) begin
            state_nxt = DONE;
          end else if (tmr == TMR_LAST) begin
            timed_out = 1'b1;
            state_nxt = IDLE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign enter_speed = (state_nxt == SPEED_WAIT) && (state != SPEED_WAIT);
  assign enter_cur   = (state_nxt == CUR_WAIT) && (state != CUR_WAIT);
  assign enter_done  = (state_nxt == DONE);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt                  <= '0;
      tmr                      <= '0;
      id_seen                  <= 1'b0;
      iq_seen                  <= 1'b0;
      fault_out                <= 1'b0;
      pid.speed_pid_enable_out <= 1'b0;
      pid.id_pid_enable_out    <= 1'b0;
      pid.iq_pid_enable_out    <= 1'b0;
      loop_done_out            <= 1'b0;
      tick_overrun_out         <= 1'b0;
    end else begin
      // Wait-state timer restarts on every state change and only runs while waiting.
      if (state_nxt != state)
        tmr <= '0;
      else if (state == SPEED_WAIT || state == CUR_WAIT)
        tmr <= tmr + 1'b1;

      if (!loop_enable_in)
        div_cnt <= '0;
      else if (accept)
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

      if (!loop_enable_in || enter_cur) begin
        id_seen <= 1'b0;
        iq_seen <= 1'b0;
      end else if (state == CUR_WAIT) begin
        if (pid.id_pid_done_in) id_seen <= 1'b1;
        if (pid.iq_pid_done_in) iq_seen <= 1'b1;
      end

      if (!loop_enable_in) fault_out <= 1'b0;
      else if (timed_out)  fault_out <= 1'b1;

      pid.speed_pid_enable_out <= enter_speed;
      pid.id_pid_enable_out    <= enter_cur;
      pid.iq_pid_enable_out    <= enter_cur;
      loop_done_out            <= enter_done;
      tick_overrun_out         <= current_tick_in && (state != IDLE);
    end
  end

  // Stage p0: input snapshot on accepted tick, references on loop progress
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_set_p0    <= '0;
      speed_detect_p0 <= '0;
      id_set_p0       <= '0;
      id_detect_p0    <= '0;
      iq_detect_p0    <= '0;
      lim_p0          <= '0;
      iq_ref_out      <= '0;
      vd_out          <= '0;
      vq_out          <= '0;
    end else begin
      if (accept) begin
        speed_set_p0    <= speed_set_in;
        speed_detect_p0 <= speed_detect_in;
        id_set_p0       <= id_set_in;
        id_detect_p0    <= id_detect_in;
        iq_detect_p0    <= iq_detect_in;
        lim_p0          <= sat_limit(iq_limit_in);
      end
      if (state == SPEED_WAIT && state_nxt == CUR_WAIT)
        iq_ref_out <= clamp_sym(pid.speed_pid_value_in, lim_p0);
      // A done arriving in the same cycle as the exit is taken directly from the bus.
      if (enter_done) begin
        vd_out <= id_seen ? id_res_p1 : pid.id_pid_value_in;
        vq_out <= iq_seen ? iq_res_p1 : pid.iq_pid_value_in;
      end
    end
  end

  // Stage p1: first result of each current PID within the wait is held
  always_ff @(posedge sys_clk) begin
    if (state == CUR_WAIT && pid.id_pid_done_in && !id_seen) id_res_p1 <= pid.id_pid_value_in;
    if (state == CUR_WAIT && pid.iq_pid_done_in && !iq_seen) iq_res_p1 <= pid.iq_pid_value_in;
  end

  assign pid.speed_pid_set_out    = speed_set_p0;
  assign pid.speed_pid_detect_out = speed_detect_p0;
  assign pid.id_pid_set_out       = id_set_p0;
  assign pid.id_pid_detect_out    = id_detect_p0;
  assign pid.iq_pid_set_out       = iq_ref_out;
  assign pid.iq_pid_detect_out    = iq_detect_p0;

endmodule

// File: tb/tb_pid_loop_scheduler.sv
module tb_pid_loop_scheduler;
  localparam int SPEED_DIV = 10;
  localparam int TIMEOUT   = 64;

  logic sys_clk = 1'b0;
  logic reset_n, loop_enable_in, current_tick_in;
  logic [15:0] speed_set_in, speed_detect_in, id_set_in, id_detect_in, iq_detect_in, iq_limit_in;
  logic [15:0] iq_ref_out, vd_out, vq_out;
  logic loop_done_out, tick_overrun_out, fault_out;

  pid_loop_scheduler_if #(.DATA_WIDTH(16)) pid ();

  pid_loop_scheduler #(.DATA_WIDTH(16), .SPEED_DIV(SPEED_DIV), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .loop_enable_in(loop_enable_in),
    .current_tick_in(current_tick_in), .speed_set_in(speed_set_in),
    .speed_detect_in(speed_detect_in), .id_set_in(id_set_in), .id_detect_in(id_detect_in),
    .iq_detect_in(iq_detect_in), .iq_limit_in(iq_limit_in), .pid(pid),
    .iq_ref_out(iq_ref_out), .vd_out(vd_out), .vq_out(vq_out), .loop_done_out(loop_done_out),
    .tick_overrun_out(tick_overrun_out), .fault_out(fault_out)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  int lat_spd = 9, lat_id = 9, lat_iq = 9;
  bit sup_iq = 0;
  logic [15:0] spd_val = 16'h0;
  int spd_cnt = 0, id_cnt = 0, iq_cnt = 0;
  int n_spd_en = 0, n_id_en = 0, n_iq_en = 0, n_loop_done = 0, n_ovr = 0;
  int last_done_cyc = 0, iq_done_cyc = 0;
  logic [15:0] seen_spd_set, seen_spd_det;

  // Reference model state
  int mdl_acc = 0;
  logic [15:0] mdl_iq_ref = 16'h0;
  logic [15:0] exp_vd = 16'h0, exp_vq = 16'h0, exp_spd_set, exp_spd_det;

  // PID unit models: fixed-latency responders. Current PIDs return set - detect
  // computed from the operands on the bus when the result is delivered.
  initial begin
    forever begin
      @(negedge sys_clk);
      cyc++;
      pid.speed_pid_done_in = 1'b0;
      pid.id_pid_done_in    = 1'b0;
      pid.iq_pid_done_in    = 1'b0;
      if (loop_done_out) begin n_loop_done++; last_done_cyc = cyc; end
      if (tick_overrun_out) n_ovr++;
      if (spd_cnt > 0) begin
        spd_cnt--;
        if (spd_cnt == 0) begin
          pid.speed_pid_value_in = spd_val;
          pid.speed_pid_done_in  = 1'b1;
          seen_spd_set = pid.speed_pid_set_out;
          seen_spd_det = pid.speed_pid_detect_out;
        end
      end
      if (id_cnt > 0) begin
        id_cnt--;
        if (id_cnt == 0) begin
          pid.id_pid_value_in = pid.id_pid_set_out - pid.id_pid_detect_out;
          pid.id_pid_done_in  = 1'b1;
        end
      end
      if (iq_cnt > 0) begin
        iq_cnt--;
        if (iq_cnt == 0 && !sup_iq) begin
          pid.iq_pid_value_in = pid.iq_pid_set_out - pid.iq_pid_detect_out;
          pid.iq_pid_done_in  = 1'b1;
          iq_done_cyc = cyc;
        end
      end
      if (pid.speed_pid_enable_out) begin n_spd_en++; spd_cnt = lat_spd; end
      if (pid.id_pid_enable_out)    begin n_id_en++;  id_cnt  = lat_id;  end
      if (pid.iq_pid_enable_out)    begin n_iq_en++;  iq_cnt  = lat_iq;  end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mdl_clamp(input logic [15:0] v, input logic [15:0] lim);
    int l, x;
    l = (lim > 16'h7FFF) ? 32'h7FFF : int'(lim);
    x = int'($signed(v));
    if (x > l) x = l;
    else if (x < -l) x = -l;
    return x[15:0];
  endfunction

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  // Drive fresh random loop inputs and advance the model by one accepted tick.
  task automatic prep_tick(input logic [15:0] sval, input logic [15:0] lim);
    logic [15:0] a, b, c;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    exp_spd_set = 16'($urandom); exp_spd_det = 16'($urandom);
    speed_set_in = exp_spd_set; speed_detect_in = exp_spd_det;
    id_set_in = a; id_detect_in = b; iq_detect_in = c; iq_limit_in = lim; spd_val = sval;
    if (mdl_acc % SPEED_DIV == 0) mdl_iq_ref = mdl_clamp(sval, lim);
    mdl_acc++;
    exp_vd = a - b;
    exp_vq = mdl_iq_ref - c;
  endtask

  task automatic scramble();
    speed_set_in = 16'($urandom); speed_detect_in = 16'($urandom);
    id_set_in = 16'($urandom); id_detect_in = 16'($urandom);
    iq_detect_in = 16'($urandom); iq_limit_in = 16'($urandom);
  endtask

  task automatic run_tick(input logic [15:0] sval, input logic [15:0] lim,
                          output bit saw_done, output int spd_en_d);
    int n0, b;
    prep_tick(sval, lim);
    n0 = n_spd_en;
    current_tick_in = 1'b1;
    step();
    current_tick_in = 1'b0;
    scramble();
    b = 0;
    while (!loop_done_out && b < 200) begin step(); b++; end
    saw_done = loop_done_out;
    spd_en_d = n_spd_en - n0;
    step();
  endtask

  task automatic restart();
    loop_enable_in = 1'b0;
    step();
    loop_enable_in = 1'b1;
    mdl_acc = 0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    tests++; if (iq_ref_out !== 16'h0) begin fails++; $display("FAIL reset_iq_ref: got %h want 0000", iq_ref_out); end
    tests++; if ({vd_out, vq_out} !== 32'h0) begin fails++; $display("FAIL reset_vd_vq: got %h want 0", {vd_out, vq_out}); end
    tests++; if ({loop_done_out, tick_overrun_out, fault_out} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {loop_done_out, tick_overrun_out, fault_out}); end
    tests++; if ({pid.speed_pid_enable_out, pid.id_pid_enable_out, pid.iq_pid_enable_out} !== 3'b000) begin fails++; $display("FAIL reset_enables: got %b want 000", {pid.speed_pid_enable_out, pid.id_pid_enable_out, pid.iq_pid_enable_out}); end
    tests++; if ({pid.speed_pid_set_out, pid.id_pid_set_out, pid.iq_pid_detect_out} !== 48'h0) begin fails++; $display("FAIL reset_operands: got %h want 0", {pid.speed_pid_set_out, pid.id_pid_set_out, pid.iq_pid_detect_out}); end
    reset_n = 1'b1;
    loop_enable_in = 1'b1;
    step();
    mdl_acc = 0;
    mdl_iq_ref = 16'h0;
  endtask

  task automatic test_first_tick();
    int n;
    lat_spd = 9; lat_id = 9; lat_iq = 9;
    prep_tick(16'h1000, 16'h2000);
    current_tick_in = 1'b1;
    step();
    current_tick_in = 1'b0;
    scramble();
    tests++; if ({pid.speed_pid_enable_out, pid.id_pid_enable_out} !== 2'b10) begin fails++; $display("FAIL first_speed_enable: got %b want 10", {pid.speed_pid_enable_out, pid.id_pid_enable_out}); end
    n = 0;
    while (!pid.iq_pid_enable_out && n < 50) begin step(); n++; end
    tests++; if (n !== 10) begin fails++; $display("FAIL first_cur_enable_delay: got %0d want 10", n); end
    tests++; if (iq_ref_out !== 16'h1000) begin fails++; $display("FAIL first_iq_ref: got %h want 1000", iq_ref_out); end
    tests++; if ({pid.id_pid_enable_out, pid.iq_pid_set_out} !== {1'b1, 16'h1000}) begin fails++; $display("FAIL first_cur_operands: got %h want 11000", {pid.id_pid_enable_out, pid.iq_pid_set_out}); end
    n = 0;
    while (!loop_done_out && n < 50) begin step(); n++; end
    tests++; if (n !== 10) begin fails++; $display("FAIL first_done_delay: got %0d want 10", n); end
    tests++; if (vd_out !== exp_vd) begin fails++; $display("FAIL first_vd: got %h want %h", vd_out, exp_vd); end
    tests++; if (vq_out !== exp_vq) begin fails++; $display("FAIL first_vq: got %h want %h", vq_out, exp_vq); end
    step();
    tests++; if (loop_done_out !== 1'b0) begin fails++; $display("FAIL first_done_width: got %b want 0", loop_done_out); end
  endtask

  task automatic test_clamp();
    logic [15:0] cv [0:5], cl [0:5], ce [0:5];
    logic [15:0] v, l;
    bit sd;
    int d;
    cv = '{16'h7000, 16'h9000, 16'h8000, 16'h7FFF, 16'hE000, 16'h2000};
    cl = '{16'h2000, 16'h2000, 16'hFFFF, 16'hFFFF, 16'h2000, 16'h2000};
    ce = '{16'h2000, 16'hE000, 16'h8001, 16'h7FFF, 16'hE000, 16'h2000};
    lat_spd = 5; lat_id = 3; lat_iq = 7;
    for (int i = 0; i < 6; i++) begin
      restart();
      run_tick(cv[i], cl[i], sd, d);
      tests++; if (iq_ref_out !== ce[i]) begin fails++; $display("FAIL clamp_case%0d: got %h want %h", i, iq_ref_out, ce[i]); end
      tests++; if (!sd || vq_out !== exp_vq) begin fails++; $display("FAIL clamp_vq%0d: got %h done %0d want %h", i, vq_out, sd, exp_vq); end
    end
    for (int i = 0; i < 6; i++) begin
      restart();
      v = 16'($urandom); l = 16'($urandom);
      run_tick(v, l, sd, d);
      tests++; if (iq_ref_out !== mdl_iq_ref) begin fails++; $display("FAIL clamp_rand v=%h l=%h: got %h want %h", v, l, iq_ref_out, mdl_iq_ref); end
    end
  endtask

  task automatic test_divider();
    bit sd;
    int d, d0;
    restart();
    d0 = n_loop_done;
    for (int t = 0; t < 25; t++) begin
      lat_spd = $urandom_range(1, 12); lat_id = $urandom_range(1, 12); lat_iq = $urandom_range(1, 12);
      run_tick(16'($urandom), 16'($urandom), sd, d);
      tests++; if (d !== ((t % SPEED_DIV == 0) ? 1 : 0)) begin fails++; $display("FAIL div_speed_runs tick%0d: got %0d want %0d", t + 1, d, (t % SPEED_DIV == 0) ? 1 : 0); end
      tests++; if (sd !== 1'b1) begin fails++; $display("FAIL div_done tick%0d: got %0d want 1", t + 1, sd); end
      tests++; if (iq_ref_out !== mdl_iq_ref) begin fails++; $display("FAIL div_iq_ref tick%0d: got %h want %h", t + 1, iq_ref_out, mdl_iq_ref); end
      tests++; if ({vd_out, vq_out} !== {exp_vd, exp_vq}) begin fails++; $display("FAIL div_vd_vq tick%0d: got %h want %h", t + 1, {vd_out, vq_out}, {exp_vd, exp_vq}); end
      if (d == 1) begin
        tests++; if ({seen_spd_set, seen_spd_det} !== {exp_spd_set, exp_spd_det}) begin fails++; $display("FAIL div_speed_operands tick%0d: got %h want %h", t + 1, {seen_spd_set, seen_spd_det}, {exp_spd_set, exp_spd_det}); end
      end
    end
    tests++; if (n_loop_done - d0 !== 25) begin fails++; $display("FAIL div_done_count: got %0d want 25", n_loop_done - d0); end
  endtask

  task automatic test_overrun();
    int s0, o0, d0, e0, b;
    restart();
    lat_spd = 6; lat_id = 4; lat_iq = 9;
    s0 = n_spd_en; o0 = n_ovr; d0 = n_loop_done;
    prep_tick(16'h0400, 16'h2000);
    current_tick_in = 1'b1; step(); current_tick_in = 1'b0;
    scramble();
    step(); step();
    current_tick_in = 1'b1; step(); current_tick_in = 1'b0;
    tests++; if (tick_overrun_out !== 1'b1) begin fails++; $display("FAIL ovr_pulse: got %b want 1", tick_overrun_out); end
    step();
    tests++; if (tick_overrun_out !== 1'b0) begin fails++; $display("FAIL ovr_width: got %b want 0", tick_overrun_out); end
    b = 0;
    while (!loop_done_out && b < 100) begin step(); b++; end
    repeat (4) step();
    tests++; if (n_loop_done - d0 !== 1) begin fails++; $display("FAIL ovr_done_count: got %0d want 1", n_loop_done - d0); end
    tests++; if (last_done_cyc !== iq_done_cyc + 1) begin fails++; $display("FAIL skew_done_after_iq: got cycle %0d want %0d", last_done_cyc, iq_done_cyc + 1); end
    tests++; if (n_spd_en - s0 !== 1 || n_ovr - o0 !== 1) begin fails++; $display("FAIL ovr_counts: got spd %0d ovr %0d want 1 1", n_spd_en - s0, n_ovr - o0); end
    tests++; if ({vd_out, vq_out} !== {exp_vd, exp_vq}) begin fails++; $display("FAIL skew_vd_vq: got %h want %h", {vd_out, vq_out}, {exp_vd, exp_vq}); end
    // Same-cycle dones, and a tick landing in the DONE cycle.
    lat_id = 5; lat_iq = 5;
    prep_tick(16'($urandom), 16'($urandom));
    current_tick_in = 1'b1; step(); current_tick_in = 1'b0;
    b = 0;
    while (!loop_done_out && b < 100) begin step(); b++; end
    e0 = n_spd_en + n_id_en + n_iq_en;
    current_tick_in = 1'b1; step(); current_tick_in = 1'b0;
    tests++; if (tick_overrun_out !== 1'b1) begin fails++; $display("FAIL ovr_in_done: got %b want 1", tick_overrun_out); end
    repeat (3) step();
    tests++; if (n_spd_en + n_id_en + n_iq_en !== e0) begin fails++; $display("FAIL ovr_in_done_enables: got %0d want %0d", n_spd_en + n_id_en + n_iq_en, e0); end
    tests++; if ({vd_out, vq_out} !== {exp_vd, exp_vq}) begin fails++; $display("FAIL same_cycle_vd_vq: got %h want %h", {vd_out, vq_out}, {exp_vd, exp_vq}); end
  endtask

  task automatic test_timeout();
    logic [15:0] old_vd, old_vq;
    int e, b, d0, en0, o0, d;
    bit sd;
    restart();
    lat_spd = 3; lat_id = 4; sup_iq = 1'b1;
    old_vd = exp_vd; old_vq = exp_vq;
    d0 = n_loop_done;
    prep_tick(16'($urandom), 16'($urandom));
    current_tick_in = 1'b1; step(); current_tick_in = 1'b0;
    b = 0;
    while (!pid.id_pid_enable_out && b < 50) begin step(); b++; end
    e = cyc;
    while (cyc < e + TIMEOUT - 1) step();
    tests++; if (fault_out !== 1'b0) begin fails++; $display("FAIL tmo_early: got %b want 0", fault_out); end
    step();
    tests++; if (fault_out !== 1'b1) begin fails++; $display("FAIL tmo_fault: got %b want 1", fault_out); end
    tests++; if ({vd_out, vq_out} !== {old_vd, old_vq}) begin fails++; $display("FAIL tmo_hold_vd_vq: got %h want %h", {vd_out, vq_out}, {old_vd, old_vq}); end
    tests++; if (iq_ref_out !== mdl_iq_ref) begin fails++; $display("FAIL tmo_iq_ref: got %h want %h", iq_ref_out, mdl_iq_ref); end
    en0 = n_spd_en + n_id_en + n_iq_en; o0 = n_ovr;
    repeat (2) begin
      current_tick_in = 1'b1; step(); current_tick_in = 1'b0;
      repeat (4) step();
    end
    tests++; if (n_spd_en + n_id_en + n_iq_en !== en0 || n_ovr !== o0) begin fails++; $display("FAIL tmo_ticks_ignored: got en %0d ovr %0d want %0d %0d", n_spd_en + n_id_en + n_iq_en, n_ovr, en0, o0); end
    tests++; if (fault_out !== 1'b1 || n_loop_done !== d0) begin fails++; $display("FAIL tmo_sticky: got fault %b done %0d want 1 %0d", fault_out, n_loop_done, d0); end
    sup_iq = 1'b0;
    loop_enable_in = 1'b0; step(); loop_enable_in = 1'b1;
    tests++; if (fault_out !== 1'b0) begin fails++; $display("FAIL tmo_clear: got %b want 0", fault_out); end
    mdl_acc = 0;
    step();
    run_tick(16'($urandom), 16'($urandom), sd, d);
    tests++; if (d !== 1 || sd !== 1'b1) begin fails++; $display("FAIL tmo_recover: got spd %0d done %0d want 1 1", d, sd); end
    tests++; if ({iq_ref_out, vd_out, vq_out} !== {mdl_iq_ref, exp_vd, exp_vq}) begin fails++; $display("FAIL tmo_recover_vals: got %h want %h", {iq_ref_out, vd_out, vq_out}, {mdl_iq_ref, exp_vd, exp_vq}); end
  endtask

  task automatic test_abort();
    int c0, d0, d;
    bit sd;
    restart();
    lat_spd = 20; lat_id = 3; lat_iq = 3;
    c0 = n_id_en + n_iq_en; d0 = n_loop_done;
    scramble();
    spd_val = 16'($urandom);
    current_tick_in = 1'b1; step(); current_tick_in = 1'b0;
    tests++; if (pid.speed_pid_enable_out !== 1'b1) begin fails++; $display("FAIL abort_speed_enable: got %b want 1", pid.speed_pid_enable_out); end
    repeat (5) step();
    loop_enable_in = 1'b0; step(); loop_enable_in = 1'b1;
    repeat (25) step();
    tests++; if (n_id_en + n_iq_en !== c0) begin fails++; $display("FAIL abort_cur_enables: got %0d want %0d", n_id_en + n_iq_en, c0); end
    tests++; if (n_loop_done !== d0) begin fails++; $display("FAIL abort_loop_done: got %0d want %0d", n_loop_done, d0); end
    tests++; if (iq_ref_out !== mdl_iq_ref) begin fails++; $display("FAIL abort_iq_ref: got %h want %h", iq_ref_out, mdl_iq_ref); end
    mdl_acc = 0;
    lat_spd = 5;
    run_tick(16'($urandom), 16'($urandom), sd, d);
    tests++; if (d !== 1 || sd !== 1'b1) begin fails++; $display("FAIL abort_next_tick: got spd %0d done %0d want 1 1", d, sd); end
    tests++; if ({iq_ref_out, vq_out} !== {mdl_iq_ref, exp_vq}) begin fails++; $display("FAIL abort_next_vals: got %h want %h", {iq_ref_out, vq_out}, {mdl_iq_ref, exp_vq}); end
  endtask

  initial begin
    reset_n = 1'b0; loop_enable_in = 1'b0; current_tick_in = 1'b0;
    speed_set_in = '0; speed_detect_in = '0; id_set_in = '0; id_detect_in = '0;
    iq_detect_in = '0; iq_limit_in = '0;
    pid.speed_pid_value_in = '0; pid.id_pid_value_in = '0; pid.iq_pid_value_in = '0;
    pid.speed_pid_done_in = 1'b0; pid.id_pid_done_in = 1'b0; pid.iq_pid_done_in = 1'b0;
    test_reset();
    test_first_tick();
    test_clamp();
    test_divider();
    test_overrun();
    test_timeout();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
